skip_add_seq: RTL
=================

// Module: skip_add_seq
// PURPOSE
//  Nibble-serial sequencer for 32-bit carry-skip addition on one shared SLICE-bit slice.
//  Accepts an operand pair over a valid/ready handshake and walks it LSB-first, one slice per cycle.
//  Each slice applies the skip rule: all-propagate slice passes carry-in, otherwise ripple carry-out.
//  Returns sum, carry-out and a count of skipped slices. Area-lean alternative to the full-width adder.
// PARAMETERS
//  WIDTH   32  operand/sum width; WIDTH % SLICE != 0 is an elaboration error
//  SLICE   4   bits processed per cycle (one slice)
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous, active-low reset
//  in_valid   in   1              operand pair a/b/ci valid
//  in_ready   out  1              block can accept (state IDLE)
//  a          in   WIDTH          operand A
//  b          in   WIDTH          operand B
//  ci         in   1              carry-in
//  out_valid  out  1              s/co/skip_cnt valid (state DONE)
//  out_ready  in   1              consumer takes result
//  s          out  WIDTH          sum, registered
//  co         out  1              carry-out, registered
//  skip_cnt   out  $clog2(NS+1)   slices whose carry was skipped (NS = WIDTH/SLICE)
//  busy       out  1              high in RUN
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, carry=0, s=0, co=0, skip_cnt=0, out_valid=0, busy=0; in_ready=1.
//  No transfer while rst_n low.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&in_ready edge: latch a,b; carry<=ci; idx<=0; s<=0; skip_cnt<=0; ->RUN.
//   RUN: each edge processes slice idx: {c_r,sum}=a_sl+b_sl+carry; P=&(a_sl^b_sl);
//        s[idx*SLICE+:SLICE]<=sum; carry<=P?carry:c_r; skip_cnt+=P; idx++.
//        At idx==NS-1: co<=final carry; ->DONE.
//   DONE: out_valid=1; s/co/skip_cnt stable. out_ready edge ->IDLE; no accept that same edge.
//  Latency: out_valid rises exactly NS edges after the accepting edge (8 at defaults).
//  Issue interval: NS+2 cycles minimum with out_ready tied high.
//  Result invariant: {co,s} == a+b+ci, mod 2^(WIDTH+1).
//  in_valid during RUN/DONE is ignored (in_ready=0); requester holds its operands.
//  out_ready outside DONE has no effect. idx never exceeds NS-1, so no wrap.
//  Reset mid-RUN/DONE aborts the op: no out_valid and no partial result are presented.
// STRUCTURE
//  skip_add_pkg: state enum typedef {IDLE,RUN,DONE}, default WIDTH/SLICE constants.
//  Sub-module skip_slice: combinational SLICE-bit ripple + propagate detect + carry skip mux.
//  Inputs a_sl, b_sl, cin; outputs sum, cout.
//  Top holds FSM, idx counter, operand/sum registers, carry flop, skip counter.
// TESTING
//  1 a=32'h0000_0001,b=32'hFFFF_FFFF,ci=0 -> s=32'h0, co=1, skip_cnt=7.
//  2 a=32'h1234_5678,b=32'h8765_4321,ci=1 -> s=32'h9999_999A, co=0, skip_cnt=0.
//  3 a=b=32'hFFFF_FFFF,ci=1 -> s=32'hFFFF_FFFF, co=1, skip_cnt=0.
//  4 Accept at edge E0 -> busy high E1..E7, out_valid rises at E8; in_valid pulses in RUN not accepted.
//  5 Hold out_ready=0 for 5 cycles in DONE -> s/co stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1.
//  6 rst_n low at idx=3 -> out_valid=0, s=0, co=0 at once.
//    After release, a=32'hFFFF_FFFF,b=0,ci=1 -> s=0, co=1, skip_cnt=8.

Source files
------------

// File: rtl/skip_add_pkg.sv
// +---------------------------------------------------------------------------+
// | skip_add_pkg : shared state encoding and default sizes for skip_add_seq   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package skip_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/skip_slice.sv
// +---------------------------------------------------------------------------+
// | skip_slice : one SLICE-bit ripple adder with carry-skip bypass            |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module skip_slice
  import skip_add_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a_sl,
  input  logic [SLICE-1:0] b_sl,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] w_full;
  logic           w_prop;

  assign w_full = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, cin};
  assign w_prop = &(a_sl ^ b_sl);
  assign sum    = w_full[SLICE-1:0];
  // An all-propagate slice forwards its carry-in straight to the next slice.
  assign cout   = w_prop ? cin : w_full[SLICE];

endmodule

`default_nettype wire

// File: rtl/skip_add_seq.sv
// +---------------------------------------------------------------------------+
// | skip_add_seq : slice-serial carry-skip adder, one SLICE per clock         |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module skip_add_seq
  import skip_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          ci,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              s,
  output logic                          co,
  output logic [$clog2(WIDTH/SLICE+1)-1:0] skip_cnt,
  output logic                          busy
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int SW = $clog2(NS + 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("skip_add_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_co;
  logic [IW-1:0]    r_idx;
  logic [SW-1:0]    r_skip;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic             w_prop;

  assign w_a_sl = r_a[r_idx*SLICE +: SLICE];
  assign w_b_sl = r_b[r_idx*SLICE +: SLICE];
  assign w_prop = &(w_a_sl ^ w_b_sl);

  skip_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_sl (w_a_sl),
    .b_sl (w_b_sl),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_idx == IW'(NS - 1)) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_idx   <= '0;
      r_skip  <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_s     <= '0;
      r_carry <= ci;
      r_idx   <= '0;
      r_skip  <= '0;
    end else if (busy) begin
      r_s[r_idx*SLICE +: SLICE] <= w_sum;
      r_carry <= w_cout;
      r_skip  <= r_skip + SW'(w_prop);
      // idx parks on the last slice instead of wrapping.
      if (w_last) r_co  <= w_cout;
      else        r_idx <= r_idx + IW'(1);
    end
  end

  assign s        = r_s;
  assign co       = r_co;
  assign skip_cnt = r_skip;

endmodule

`default_nettype wire
